// File: rtl/tthbif_cfg_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tthbif_cfg_regfile
//  Description : UART command decoder and configuration register file for
//                tthbif. Decodes a byte protocol (opcode byte, optional data
//                byte) into register reads/writes. It drives the tthbif
//                enable and the rx/tx flop/comb tap selects. Read data is
//                returned on the uart tx byte path.
//  Ports       : clk_i / rst_ni            clock, async active-low reset
//                rx_data_valid_i/rx_data_i received byte strobe and data
//                tx_data_ready_i           uart tx accepts a byte
//                tx_data_valid_o/tx_data_o response byte
//                en_o                      CTRL[0]
//                rx/tx_flop/comb_tap_sel_o TAPSEL fields [1:0],[3:2],[5:4],[7:6]
//  Revision    : 1.0  initial release
// ============================================================================
module tthbif_cfg_regfile #(
    parameter int         TAP_SEL_W      = 2,
    parameter logic [7:0] ID_VALUE       = 8'hB1,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_data_valid_i,
    input  logic [7:0]           rx_data_i,
    input  logic                 tx_data_ready_i,
    output logic                 tx_data_valid_o,
    output logic [7:0]           tx_data_o,
    output logic                 en_o,
    output logic [TAP_SEL_W-1:0] rx_flop_tap_sel_o,
    output logic [TAP_SEL_W-1:0] rx_comb_tap_sel_o,
    output logic [TAP_SEL_W-1:0] tx_flop_tap_sel_o,
    output logic [TAP_SEL_W-1:0] tx_comb_tap_sel_o
);

    localparam int              c_CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_ADDR_CTRL    = 3'd0;
    localparam logic [2:0] c_ADDR_TAPSEL  = 3'd1;
    localparam logic [2:0] c_ADDR_ID      = 3'd2;
    localparam logic [2:0] c_ADDR_SCRATCH = 3'd3;
    localparam logic [2:0] c_ADDR_STATUS  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WDATA = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t             r_state;
    logic [2:0]         r_addr;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_en;
    logic [7:0]         r_tapsel;
    logic [7:0]         r_scratch;
    logic [2:0]         r_status;   // {bad_cmd, timeout, drop}
    logic               r_tx_valid;
    logic [7:0]         r_tx_data;

    logic               w_opc_bad;
    logic               w_set_bad;
    logic               w_set_to;
    logic               w_set_drop;
    logic [2:0]         w_clr;
    logic [2:0]         w_status_nxt;
    logic [7:0]         w_rd_data;

    assign w_opc_bad  = |rx_data_i[6:3];
    assign w_set_bad  = (r_state == S_IDLE)  && rx_data_valid_i && w_opc_bad;
    assign w_set_drop = (r_state == S_RESP)  && rx_data_valid_i;
    assign w_set_to   = (r_state == S_WDATA) && !rx_data_valid_i && (r_cnt == c_CNT_MAX);

    // Clear is applied first so a coincident set event always survives.
    always_comb begin
        w_clr = 3'b000;
        if ((r_state == S_WDATA) && rx_data_valid_i && (r_addr == c_ADDR_STATUS)) begin
            w_clr = rx_data_i[2:0];
        end
        w_status_nxt = (r_status & ~w_clr) | {w_set_bad, w_set_to, w_set_drop};
    end

    // Read mux indexed straight off the incoming opcode so the response is
    // captured at the acceptance cycle.
    always_comb begin
        w_rd_data = 8'h00;
        case (rx_data_i[2:0])
            c_ADDR_CTRL:    w_rd_data = {7'b0, r_en};
            c_ADDR_TAPSEL:  w_rd_data = r_tapsel;
            c_ADDR_ID:      w_rd_data = ID_VALUE;
            c_ADDR_SCRATCH: w_rd_data = r_scratch;
            c_ADDR_STATUS:  w_rd_data = {5'b0, r_status};
            default:        w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_addr     <= 3'd0;
            r_cnt      <= '0;
            r_en       <= 1'b0;
            r_tapsel   <= 8'hFF;
            r_scratch  <= 8'h00;
            r_status   <= 3'b000;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_status <= w_status_nxt;
            case (r_state)
                S_IDLE: begin
                    if (rx_data_valid_i && !w_opc_bad) begin
                        if (rx_data_i[7]) begin
                            r_addr  <= rx_data_i[2:0];
                            r_cnt   <= '0;
                            r_state <= S_WDATA;
                        end else begin
                            r_tx_data  <= w_rd_data;
                            r_tx_valid <= 1'b1;
                            r_state    <= S_RESP;
                        end
                    end
                end
                S_WDATA: begin
                    // A byte on the expiry cycle takes priority over timeout.
                    if (rx_data_valid_i) begin
                        case (r_addr)
                            c_ADDR_CTRL:    r_en      <= rx_data_i[0];
                            c_ADDR_TAPSEL:  r_tapsel  <= rx_data_i;
                            c_ADDR_SCRATCH: r_scratch <= rx_data_i;
                            default:        ;
                        endcase
                        r_state <= S_IDLE;
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (r_tx_valid && tx_data_ready_i) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_data_valid_o   = r_tx_valid;
    assign tx_data_o         = r_tx_data;
    assign en_o              = r_en;
    assign rx_flop_tap_sel_o = r_tapsel[0*TAP_SEL_W +: TAP_SEL_W];
    assign rx_comb_tap_sel_o = r_tapsel[1*TAP_SEL_W +: TAP_SEL_W];
    assign tx_flop_tap_sel_o = r_tapsel[2*TAP_SEL_W +: TAP_SEL_W];
    assign tx_comb_tap_sel_o = r_tapsel[3*TAP_SEL_W +: TAP_SEL_W];

endmodule
`default_nettype wire

// File: tb/tb_tthbif_cfg_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tthbif_cfg_regfile
//  Description : Self-checking bench for tthbif_cfg_regfile. A table of
//                register read/write vectors plus hand-written sequences for
//                response backpressure, dropped bytes, timeout boundary,
//                bad opcodes and asynchronous reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tthbif_cfg_regfile;

    localparam int c_T = 20;   // shortened timeout

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       en;
    logic [1:0] rx_flop, rx_comb, tx_flop, tx_comb;
    logic [7:0] w_taps;

    int total = 0;
    int bad   = 0;

    tthbif_cfg_regfile #(
        .TAP_SEL_W      (2),
        .ID_VALUE       (8'hB1),
        .TIMEOUT_CYCLES (c_T)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .rx_data_valid_i   (rx_valid),
        .rx_data_i         (rx_data),
        .tx_data_ready_i   (tx_ready),
        .tx_data_valid_o   (tx_valid),
        .tx_data_o         (tx_data),
        .en_o              (en),
        .rx_flop_tap_sel_o (rx_flop),
        .rx_comb_tap_sel_o (rx_comb),
        .tx_flop_tap_sel_o (tx_flop),
        .tx_comb_tap_sel_o (tx_comb)
    );

    assign w_taps = {tx_comb, tx_flop, rx_comb, rx_flop};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
        logic       exp_en;
        logic [7:0] exp_taps;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Byte presented for exactly one rising edge; returns on the negedge after.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        send_byte({5'b10000, a});
        send_byte(d);
    endtask

    task automatic do_read(input string name, input logic [2:0] a, input logic [7:0] exp);
        send_byte({5'b00000, a});
        chk({name, " valid"}, 32'(tx_valid), 32'd1);
        chk({name, " data"}, 32'(tx_data), 32'(exp));
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk({name, " valid drop"}, 32'(tx_valid), 32'd0);
    endtask

    initial begin
        int unstable;

        //            wr    addr  data   exp_rd exp_en exp_taps
        vecs[0]  = '{1'b0, 3'd2, 8'h00, 8'hB1, 1'b0, 8'hFF};
        vecs[1]  = '{1'b1, 3'd1, 8'h1B, 8'h00, 1'b0, 8'h1B};
        vecs[2]  = '{1'b0, 3'd1, 8'h00, 8'h1B, 1'b0, 8'h1B};
        vecs[3]  = '{1'b1, 3'd0, 8'h01, 8'h00, 1'b1, 8'h1B};
        vecs[4]  = '{1'b1, 3'd3, 8'h5A, 8'h00, 1'b1, 8'h1B};
        vecs[5]  = '{1'b0, 3'd3, 8'h00, 8'h5A, 1'b1, 8'h1B};
        vecs[6]  = '{1'b0, 3'd0, 8'h00, 8'h01, 1'b1, 8'h1B};
        vecs[7]  = '{1'b1, 3'd2, 8'h33, 8'h00, 1'b1, 8'h1B};
        vecs[8]  = '{1'b0, 3'd2, 8'h00, 8'hB1, 1'b1, 8'h1B};
        vecs[9]  = '{1'b1, 3'd6, 8'hFF, 8'h00, 1'b1, 8'h1B};
        vecs[10] = '{1'b0, 3'd6, 8'h00, 8'h00, 1'b1, 8'h1B};
        vecs[11] = '{1'b0, 3'd5, 8'h00, 8'h00, 1'b1, 8'h1B};
        vecs[12] = '{1'b0, 3'd7, 8'h00, 8'h00, 1'b1, 8'h1B};
        vecs[13] = '{1'b0, 3'd4, 8'h00, 8'h00, 1'b1, 8'h1B};
        vecs[14] = '{1'b1, 3'd1, 8'hE4, 8'h00, 1'b1, 8'hE4};
        vecs[15] = '{1'b1, 3'd0, 8'hFE, 8'h00, 1'b0, 8'hE4};
        vecs[16] = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'hE4};

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset en", 32'(en), 32'd0);
        chk("reset rx_flop", 32'(rx_flop), 32'd3);
        chk("reset rx_comb", 32'(rx_comb), 32'd3);
        chk("reset tx_flop", 32'(tx_flop), 32'd3);
        chk("reset tx_comb", 32'(tx_comb), 32'd3);
        chk("reset tx_valid", 32'(tx_valid), 32'd0);
        chk("reset tx_data", 32'(tx_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- table-driven register accesses ----------------
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data);
                chk($sformatf("vec%0d wr no tx", i), 32'(tx_valid), 32'd0);
            end else begin
                do_read($sformatf("vec%0d rd", i), vecs[i].addr, vecs[i].exp_rd);
            end
            chk($sformatf("vec%0d en", i), 32'(en), 32'(vecs[i].exp_en));
            chk($sformatf("vec%0d taps", i), 32'(w_taps), 32'(vecs[i].exp_taps));
        end

        // ---------------- response held under backpressure, byte dropped ----------------
        do_write(3'd3, 8'h5A);
        send_byte(8'h03);
        unstable = 0;
        for (int c = 0; c < 50; c++) begin
            if (c == 10) begin
                rx_valid = 1'b1;
                rx_data  = 8'h10;
            end else begin
                rx_valid = 1'b0;
                rx_data  = 8'h00;
            end
            if (tx_valid !== 1'b1 || tx_data !== 8'h5A) unstable++;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        chk("hold unstable cycles", 32'(unstable), 32'd0);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk("hold valid drop", 32'(tx_valid), 32'd0);
        do_read("status drop", 3'd4, 8'h01);
        do_read("scratch after drop", 3'd3, 8'h5A);
        do_write(3'd4, 8'h01);
        do_read("status cleared", 3'd4, 8'h00);

        // ---------------- byte on the handshake cycle is also dropped ----------------
        send_byte(8'h03);
        tx_ready = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h83;
        @(negedge clk);
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        chk("hs drop valid", 32'(tx_valid), 32'd0);
        do_read("status hs drop", 3'd4, 8'h01);

        // ---------------- timeout: first byte one cycle after expiry is an opcode ----------------
        send_byte(8'h83);
        repeat (c_T - 1) @(negedge clk);
        do_read("post-timeout opcode", 3'd2, 8'hB1);
        do_read("status timeout", 3'd4, 8'h03);
        do_read("scratch after timeout", 3'd3, 8'h5A);
        do_write(3'd4, 8'h02);
        do_read("status w1c timeout", 3'd4, 8'h01);

        // ---------------- malformed opcode ----------------
        send_byte(8'h48);
        chk("bad opcode no tx", 32'(tx_valid), 32'd0);
        @(negedge clk);
        chk("bad opcode no tx later", 32'(tx_valid), 32'd0);
        do_read("status bad_cmd", 3'd4, 8'h05);
        do_read("ctrl after bad opcode", 3'd0, 8'h00);

        // ---------------- data byte on the exact expiry cycle wins ----------------
        send_byte(8'h83);
        repeat (c_T - 2) @(negedge clk);
        send_byte(8'hC3);
        chk("expiry write no tx", 32'(tx_valid), 32'd0);
        do_read("scratch expiry write", 3'd3, 8'hC3);
        do_read("status no timeout", 3'd4, 8'h05);
        do_write(3'd4, 8'h07);
        do_read("status all clear", 3'd4, 8'h00);

        // ---------------- asynchronous reset with a response pending ----------------
        do_write(3'd0, 8'h01);
        send_byte(8'h03);
        chk("pre-reset valid", 32'(tx_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", 32'(tx_valid), 32'd0);
        chk("async rst data", 32'(tx_data), 32'd0);
        chk("async rst en", 32'(en), 32'd0);
        chk("async rst taps", 32'(w_taps), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset idle", 32'(tx_valid), 32'd0);
        do_read("scratch after reset", 3'd3, 8'h00);
        do_read("tapsel after reset", 3'd1, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
